// File: rtl/divfreq_pkg.sv
// Shared encodings and reset defaults for the divfreq run controller.
package divfreq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam int unsigned DEF_NBT_C   = 30;
  localparam int unsigned DEF_NBTON_C = 10;

endpackage

// File: rtl/divfreq_core.sv
// Period counter and compare stage; Cnt, ClkOut and PeriodEnd are registered together.
module divfreq_core #(
  parameter int unsigned BUS_SIZE = 8,
  parameter bit          POLARITY = 1'b1
) (
  input  logic                ClkIn,
  input  logic                Reset,
  input  logic                En,
  input  logic [BUS_SIZE-1:0] Nbt,
  input  logic [BUS_SIZE-1:0] NbtOn,
  output logic                ClkOut,
  output logic                PeriodEnd
);

  logic                run_q;
  logic [BUS_SIZE-1:0] cnt_q, cnt_d;
  logic                clk_q, pe_q;

  // En, Nbt and NbtOn describe the upcoming cycle, so outputs line up with Cnt
  always_comb begin
    cnt_d = '0;
    if (En && run_q && !pe_q) cnt_d = cnt_q + BUS_SIZE'(1);
  end

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      clk_q <= ~POLARITY;
      pe_q  <= 1'b0;
    end else begin
      run_q <= En;
      cnt_q <= cnt_d;
      clk_q <= (En && (cnt_d < NbtOn)) ? POLARITY : ~POLARITY;
      pe_q  <= En && (cnt_d == Nbt);
    end
  end

  assign ClkOut    = clk_q;
  assign PeriodEnd = pe_q;

endmodule

// File: rtl/divfreq_ctrl.sv
// Run controller: FSM, pending/active config registers, burst counter and handshake.
module divfreq_ctrl
  import divfreq_pkg::*;
#(
  parameter int unsigned BUS_SIZE   = 8,
  parameter int unsigned BURST_SIZE = 8,
  parameter bit          POLARITY   = 1'b1,
  parameter int unsigned DEF_NBT    = DEF_NBT_C,
  parameter int unsigned DEF_NBTON  = DEF_NBTON_C
) (
  input  logic                  ClkIn,
  input  logic                  Reset,
  input  logic                  CfgValid,
  output logic                  CfgReady,
  input  logic [BUS_SIZE-1:0]   CfgNbt,
  input  logic [BUS_SIZE-1:0]   CfgNbtOn,
  input  logic [BURST_SIZE-1:0] CfgBurst,
  input  logic                  Start,
  input  logic                  Stop,
  output logic                  ClkOut,
  output logic                  PeriodEnd,
  output logic                  Busy,
  output logic                  Done
);

  state_e                state_q, state_d;
  logic [BUS_SIZE-1:0]   nbt_act_q, nbt_act_d, nbton_act_q, nbton_act_d;
  logic [BURST_SIZE-1:0] burst_act_q, burst_act_d;
  logic [BUS_SIZE-1:0]   pnd_nbt_q, pnd_nbt_d, pnd_nbton_q, pnd_nbton_d;
  logic [BURST_SIZE-1:0] pnd_burst_q, pnd_burst_d;
  logic                  pnd_vld_q, pnd_vld_d;
  logic [BURST_SIZE-1:0] rem_q, rem_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer, running, period_end, core_en;

  always_comb begin
    state_d     = state_q;
    nbt_act_d   = nbt_act_q;
    nbton_act_d = nbton_act_q;
    burst_act_d = burst_act_q;
    pnd_nbt_d   = pnd_nbt_q;
    pnd_nbton_d = pnd_nbton_q;
    pnd_burst_d = pnd_burst_q;
    pnd_vld_d   = pnd_vld_q;
    rem_d       = rem_q;
    xfer        = CfgValid & ready_q;
    running     = (state_q != ST_IDLE);

    // Config path: active registers only change while idle or on a period boundary
    if (!running) begin
      if (pnd_vld_q) begin
        nbt_act_d   = pnd_nbt_q;
        nbton_act_d = pnd_nbton_q;
        burst_act_d = pnd_burst_q;
        pnd_vld_d   = 1'b0;
      end
      if (xfer) begin
        pnd_nbt_d   = CfgNbt;
        pnd_nbton_d = CfgNbtOn;
        pnd_burst_d = CfgBurst;
        pnd_vld_d   = 1'b1;
      end
    end else if (period_end) begin
      if (xfer) begin
        nbt_act_d   = CfgNbt;
        nbton_act_d = CfgNbtOn;
        burst_act_d = CfgBurst;
      end else if (pnd_vld_q) begin
        nbt_act_d   = pnd_nbt_q;
        nbton_act_d = pnd_nbton_q;
        burst_act_d = pnd_burst_q;
        pnd_vld_d   = 1'b0;
      end
    end else if (xfer) begin
      pnd_nbt_d   = CfgNbt;
      pnd_nbton_d = CfgNbtOn;
      pnd_burst_d = CfgBurst;
      pnd_vld_d   = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (Start && !Stop) begin
          state_d = ST_RUN;
          rem_d   = burst_act_d;
        end
      end
      ST_RUN: begin
        if (period_end) begin
          if (Stop || (rem_q == BURST_SIZE'(1))) state_d = ST_IDLE;
          if (rem_q != '0) rem_d = rem_q - BURST_SIZE'(1);
        end else if (Stop) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (period_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = !pnd_vld_d;
    busy_d  = (state_d != ST_IDLE);
    done_d  = running && (state_d == ST_IDLE);
    core_en = (state_d != ST_IDLE);
  end

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      nbt_act_q   <= BUS_SIZE'(DEF_NBT);
      nbton_act_q <= BUS_SIZE'(DEF_NBTON);
      burst_act_q <= '0;
      pnd_nbt_q   <= '0;
      pnd_nbton_q <= '0;
      pnd_burst_q <= '0;
      pnd_vld_q   <= 1'b0;
      rem_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nbt_act_q   <= nbt_act_d;
      nbton_act_q <= nbton_act_d;
      burst_act_q <= burst_act_d;
      pnd_nbt_q   <= pnd_nbt_d;
      pnd_nbton_q <= pnd_nbton_d;
      pnd_burst_q <= pnd_burst_d;
      pnd_vld_q   <= pnd_vld_d;
      rem_q       <= rem_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  divfreq_core #(
    .BUS_SIZE (BUS_SIZE),
    .POLARITY (POLARITY)
  ) u_core (
    .ClkIn     (ClkIn),
    .Reset     (Reset),
    .En        (core_en),
    .Nbt       (nbt_act_d),
    .NbtOn     (nbton_act_d),
    .ClkOut    (ClkOut),
    .PeriodEnd (period_end)
  );

  assign PeriodEnd = period_end;
  assign CfgReady  = ready_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule
